enigma_rotor_ctrl: RTL
======================

// Module: enigma_rotor_ctrl
// PURPOSE
//  Initiator/driver for one rotor slice: accepts config words and a character stream, issues the rotor's
//  set/valid/en/dec strobes, waits for its done, returns the result on a valid/ready output channel.
//  Sits between the keyboard/host stream and the rotor; the rotor is the responder on rot_*.
// PARAMETERS
//  TIMEOUT   64   max STEP cycles waiting for rot_done before the char is aborted with out_err
//  CNT_W     16   width of chars_done counter (wraps at 2^CNT_W)
// PORTS
//  clk         in   1    clock, rising edge
//  reset_n     in   1    reset, asynchronous, active-low
//  cfg_valid   in   1    config load request (1-cycle accept when cfg_ready)
//  cfg_ready   out  1    =1 only in IDLE with no output pending
//  cfg_offset  in   32   per-step rotation, 0..25
//  cfg_delay   in   32   rotor processing delay
//  cfg_idx     in   208  wiring table, 26 ASCII bytes, entry 0 at [207:200]
//  in_valid    in   1    character request
//  in_ready    out  1    =1 in IDLE, no output pending, cfg_valid=0
//  in_data     in   8    ASCII character
//  in_dec      in   1    0 encode, 1 decode
//  out_valid   out  1    result valid, held until out_ready
//  out_ready   in   1    downstream accept
//  out_data    out  8    result character
//  out_err     out  1    result flag: timeout or no config loaded
//  rot_set     out  1    1-cycle pulse, loads rot_offset/rot_delay/rot_idx into rotor
//  rot_offset  out  32   registered cfg_offset
//  rot_delay   out  32   registered cfg_delay
//  rot_idx     out  208  registered cfg_idx
//  rot_valid   out  1    1-cycle pulse, rotor latches rot_din
//  rot_din     out  8    registered character
//  rot_dec     out  1    registered mode, stable from ISSUE through end of STEP
//  rot_en      out  1    step strobe, high every STEP cycle
//  rot_dout    in   8    rotor result, sampled when rot_done=1
//  rot_done    in   1    rotor completion
//  busy        out  1    =1 in any state except IDLE
//  chars_done  out  CNT_W count of out handshakes completed
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cfg_loaded=0, step counter 0; mid-op reset aborts without any rot_* pulse.
//  States: IDLE, CFG, ISSUE, STEP, OUT. All rot_* strobes are registered outputs of the state.
//  IDLE: cfg_valid has priority over in_valid. cfg accept -> capture cfg_* -> CFG.
//   in accept (in_valid&in_ready) with in_data outside 'A'..'Z' (65..90): bypass, out_data=in_data, out_err=0 -> OUT.
//   in accept, letter, cfg_loaded=0: out_data=in_data, out_err=1 -> OUT, no rotor traffic.
//   in accept, letter, cfg_loaded=1: capture in_data/in_dec into rot_din/rot_dec -> ISSUE.
//  CFG (1 cycle): rot_set=1, cfg_loaded<=1 -> IDLE.
//  ISSUE (1 cycle): rot_valid=1, step counter cleared -> STEP.
//  STEP: rot_en=1 every cycle, counter +1 per cycle.
//   rot_done=1: out_data<=rot_dout, out_err<=0, rot_en drops next cycle -> OUT. rot_done checked before timeout.
//   counter reaches TIMEOUT-1 without done: out_data<=0, out_err<=1 -> OUT.
//   rot_done outside STEP is ignored.
//  OUT: out_valid=1, out_data/out_err stable; out_ready=1 -> chars_done+1, out_valid<=0 -> IDLE next cycle.
//  Latency (accept at cycle T): rot_valid at T+1, rot_en from T+2; done seen at cycle D -> out_valid at D+1.
//   Bypass/err path: out_valid at T+1. Throughput: one char in flight; in_ready=0 until OUT handshake.
//  chars_done wraps to 0 after 2^CNT_W-1. rot_offset/delay/idx hold their value until next CFG.
// TESTING (bench uses rotor stub: done after cfg_delay-1 en cycles, dout=din+1)
//  reset, cfg offset=1 delay=3 -> rot_set one cycle, rot_offset=1, rot_delay=3, busy back to 0.
//  'A' (0x41) enc -> rot_valid 1 cycle with rot_din=0x41, rot_en 2 cycles, out_data=0x42, out_err=0.
//  ' ' (0x20) -> no rot_valid, out_valid next cycle, out_data=0x20; also letter before any cfg -> out_err=1.
//  stub never asserts done -> rot_en for exactly 64 cycles, out_data=0x00, out_err=1.
//  out_ready held 0 for 5 cycles -> out_valid/out_data stable, in_ready=0; then chars_done increments by 1.
//  reset_n low during STEP -> rot_en/out_valid 0 immediately; cfg_loaded=0, next letter returns out_err=1.

Source files
------------

// File: rtl/enigma_rotor_ctrl.sv
// enigma_rotor_ctrl: drives one rotor slice. Loads the rotor configuration,
// issues one character at a time, waits for rot_done or a timeout, then holds
// the result on a valid/ready output channel until it is taken.
module enigma_rotor_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [31:0]      cfg_offset,
  input  logic [31:0]      cfg_delay,
  input  logic [207:0]     cfg_idx,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic             rot_set,
  output logic [31:0]      rot_offset,
  output logic [31:0]      rot_delay,
  output logic [207:0]     rot_idx,
  output logic             rot_valid,
  output logic [7:0]       rot_din,
  output logic             rot_dec,
  output logic             rot_en,
  input  logic [7:0]       rot_dout,
  input  logic             rot_done,
  output logic             busy,
  output logic [CNT_W-1:0] chars_done
);

  localparam int TO_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_ISSUE,
    S_STEP,
    S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_rot_set;
  logic             r_rot_valid;
  logic             r_rot_en;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_err;
  logic [31:0]      r_rot_offset;
  logic [31:0]      r_rot_delay;
  logic [207:0]     r_rot_idx;
  logic [7:0]       r_rot_din;
  logic             r_rot_dec;
  logic             r_cfg_loaded;
  logic [TO_W-1:0]  r_step_cnt;
  logic [CNT_W-1:0] r_chars_done;

  logic             w_idle;
  logic             w_cfg_acc;
  logic             w_in_acc;
  logic             w_is_letter;
  logic             w_timeout;
  logic             w_out_hs;

  assign w_idle      = (r_state == S_IDLE) && !r_out_valid;
  assign cfg_ready   = w_idle;
  assign in_ready    = w_idle && !cfg_valid;
  assign w_cfg_acc   = cfg_valid && w_idle;
  assign w_in_acc    = in_valid && in_ready;
  assign w_is_letter = (in_data >= 8'd65) && (in_data <= 8'd90);
  assign w_timeout   = (r_step_cnt == TO_W'(TIMEOUT - 1));
  assign w_out_hs    = r_out_valid && out_ready;

  assign busy       = (r_state != S_IDLE);
  assign rot_set    = r_rot_set;
  assign rot_valid  = r_rot_valid;
  assign rot_en     = r_rot_en;
  assign rot_offset = r_rot_offset;
  assign rot_delay  = r_rot_delay;
  assign rot_idx    = r_rot_idx;
  assign rot_din    = r_rot_din;
  assign rot_dec    = r_rot_dec;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_err    = r_out_err;
  assign chars_done = r_chars_done;

  // Next-state decode; config requests win over characters in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cfg_acc) begin
          w_state_nxt = S_CFG;
        end else if (w_in_acc) begin
          w_state_nxt = (w_is_letter && r_cfg_loaded) ? S_ISSUE : S_OUT;
        end
      end
      S_CFG:   w_state_nxt = S_IDLE;
      S_ISSUE: w_state_nxt = S_STEP;
      S_STEP: begin
        // A done in the last allowed cycle still counts as success.
        if (rot_done || w_timeout) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Strobes are registered copies of the upcoming state, so they are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rot_set   <= 1'b0;
      r_rot_valid <= 1'b0;
      r_rot_en    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_rot_set   <= (w_state_nxt == S_CFG);
      r_rot_valid <= (w_state_nxt == S_ISSUE);
      r_rot_en    <= (w_state_nxt == S_STEP);
      r_out_valid <= (w_state_nxt == S_OUT);
    end
  end

  // Config capture; the rotor view of the config holds until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rot_offset <= '0;
      r_rot_delay  <= '0;
      r_rot_idx    <= '0;
      r_cfg_loaded <= 1'b0;
    end else begin
      if (w_cfg_acc) begin
        r_rot_offset <= cfg_offset;
        r_rot_delay  <= cfg_delay;
        r_rot_idx    <= cfg_idx;
      end
      if (r_state == S_CFG) begin
        r_cfg_loaded <= 1'b1;
      end
    end
  end

  // Character capture, step counting and result formation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rot_din  <= '0;
      r_rot_dec  <= 1'b0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_acc && !cfg_valid) begin
            if (!w_is_letter) begin
              // Non-letters pass straight through untouched.
              r_out_data <= in_data;
              r_out_err  <= 1'b0;
            end else if (!r_cfg_loaded) begin
              // Letter with no wiring loaded: echo it back flagged.
              r_out_data <= in_data;
              r_out_err  <= 1'b1;
            end else begin
              r_rot_din <= in_data;
              r_rot_dec <= in_dec;
            end
          end
        end
        S_ISSUE: r_step_cnt <= '0;
        S_STEP: begin
          if (rot_done) begin
            r_out_data <= rot_dout;
            r_out_err  <= 1'b0;
          end else if (w_timeout) begin
            r_out_data <= '0;
            r_out_err  <= 1'b1;
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Completed output handshakes; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chars_done <= '0;
    end else if (w_out_hs) begin
      r_chars_done <= r_chars_done + 1'b1;
    end
  end

endmodule
